// File: rtl/perceptron_mac_controller.sv
// Streams {weight, input} pairs from a block RAM over [start_addr, end_addr),
// accumulates their signed fixed-point products on top of a bias, then
// saturates, applies the selected activation and raises a one-cycle done.
module perceptron_mac_controller #(
  parameter int DATA_W       = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ADDR_W       = 9,
  parameter int ACC_W        = 2*DATA_W+ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic [ADDR_W-1:0]          end_addr,
  input  logic signed [DATA_W-1:0]   bias,
  input  logic signed [DATA_W-1:0]   threshold,
  input  logic [1:0]                 mode,
  input  logic [2*DATA_W-1:0]        bram_data_in,
  output logic [ADDR_W-1:0]          bram_data_addr,
  output logic                       bram_en,
  output logic signed [DATA_W-1:0]   perceptron_out,
  output logic                       fire,
  output logic                       busy,
  output logic                       done
);

  localparam int RL = READ_LATENCY;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
  localparam logic [DATA_W-1:0] STEP_ONE = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          end_l;
  logic signed [DATA_W-1:0]   thr_l;
  logic [1:0]                 mode_l;
  logic [ADDR_W-1:0]          addr_nxt;

  // Stages behind bram_en: bit RL-1 marks valid read data, bit RL a valid product.
  logic [RL:0]                vld_sh;
  logic signed [DATA_W-1:0]   weight_p0;
  logic signed [DATA_W-1:0]   input_p0;
  logic signed [2*DATA_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]    acc_p2;
  logic signed [DATA_W-1:0]   sat_sum;
  logic                       fire_c;

  // Drop the fractional bits and clamp into the signed output range.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_BITS;
    if (s > SAT_MAX)      saturate = SAT_MAX[DATA_W-1:0];
    else if (s < SAT_MIN) saturate = SAT_MIN[DATA_W-1:0];
    else                  saturate = s[DATA_W-1:0];
  endfunction

  // Activation select; the reserved code falls through to linear.
  function automatic logic signed [DATA_W-1:0] activate(input logic signed [DATA_W-1:0] s,
                                                        input logic f,
                                                        input logic [1:0] m);
    case (m)
      2'd0:    activate = f ? $signed(STEP_ONE) : '0;
      2'd1:    activate = s[DATA_W-1] ? '0 : s;
      default: activate = s;
    endcase
  endfunction

  assign weight_p0 = bram_data_in[2*DATA_W-1:DATA_W];
  assign input_p0  = bram_data_in[DATA_W-1:0];
  assign addr_nxt  = bram_data_addr + 1'b1;
  assign sat_sum   = saturate(acc_p2);
  assign fire_c    = (sat_sum >= thr_l);

  // Control FSM: address issue, drain wait and registered result/handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bram_data_addr <= '0;
      bram_en        <= 1'b0;
      perceptron_out <= '0;
      fire           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      end_l          <= '0;
      thr_l          <= '0;
      mode_l         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            end_l          <= end_addr;
            thr_l          <= threshold;
            mode_l         <= mode;
            bram_data_addr <= start_addr;
            busy           <= 1'b1;
            if (end_addr > start_addr) begin
              bram_en <= 1'b1;
              state   <= RUN;
            end else begin
              state   <= DRAIN;
            end
          end
        end
        RUN: begin
          if (addr_nxt < end_l) begin
            bram_data_addr <= addr_nxt;
          end else begin
            bram_en <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          // The last stage may still be accumulating at this edge; FINISH reads the result one edge later.
          if (!bram_en && vld_sh[RL-1:0] == '0) state <= FINISH;
        end
        FINISH: begin
          perceptron_out <= activate(sat_sum, fire_c, mode_l);
          fire           <= fire_c;
          done           <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p0 -> p1: valid tracking and product register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sh  <= '0;
      prod_p1 <= '0;
    end else begin
      vld_sh <= {vld_sh[RL-1:0], bram_en};
      if (vld_sh[RL-1]) prod_p1 <= weight_p0 * input_p0;
    end
  end

  // ---- p1 -> p2: bias preload on start, then accumulate valid products ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
    end else if (state == IDLE && enable) begin
      acc_p2 <= $signed({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias}) <<< FRAC_BITS;
    end else if (vld_sh[RL]) begin
      acc_p2 <= acc_p2 + $signed({{(ACC_W-2*DATA_W){prod_p1[2*DATA_W-1]}}, prod_p1});
    end
  end

endmodule

// File: tb/tb_perceptron_mac_controller.sv
// Bench for perceptron_mac_controller: a READ_LATENCY=1 and a READ_LATENCY=2
// instance share one BRAM image and one stimulus stream.
module tb_perceptron_mac_controller;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [8:0]         start_addr, end_addr;
  logic signed [15:0] bias, threshold;
  logic [1:0]         mode;

  logic [31:0]        mem [512];
  logic [31:0]        rd1, st2a, rd2;

  logic [8:0]         addr1, addr2;
  logic               en1, en2, fire1, fire2, busy1, busy2, done1, done2;
  logic signed [15:0] out1, out2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perceptron_mac_controller #(.DATA_W(16), .FRAC_BITS(0), .ADDR_W(9), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start_addr(start_addr), .end_addr(end_addr),
    .bias(bias), .threshold(threshold), .mode(mode), .bram_data_in(rd1),
    .bram_data_addr(addr1), .bram_en(en1), .perceptron_out(out1), .fire(fire1),
    .busy(busy1), .done(done1));

  perceptron_mac_controller #(.DATA_W(16), .FRAC_BITS(0), .ADDR_W(9), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start_addr(start_addr), .end_addr(end_addr),
    .bias(bias), .threshold(threshold), .mode(mode), .bram_data_in(rd2),
    .bram_data_addr(addr2), .bram_en(en2), .perceptron_out(out2), .fire(fire2),
    .busy(busy2), .done(done2));

  // BRAM models with one and two cycles of read latency.
  always @(posedge clk) begin
    if (en1) rd1 <= mem[addr1];
    if (en2) st2a <= mem[addr2];
    rd2 <= st2a;
  end

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // kind 0: words 0..7 = {2,2}; kind 1: words 0..3 = {-3,5}; kind 2: words 0..7 = {32767,32767}
  task automatic load_mem(input int kind);
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    case (kind)
      0:       for (int i = 0; i < 8; i++) mem[i] = {16'sd2, 16'sd2};
      1:       for (int i = 0; i < 4; i++) mem[i] = {-16'sd3, 16'sd5};
      default: for (int i = 0; i < 8; i++) mem[i] = {16'sd32767, 16'sd32767};
    endcase
  endtask

  // One evaluation observed for 40 cycles after E0. poke_c: cycle at which a
  // second enable (mode 0, threshold 32, bias 0) is pulsed; rst_c: cycle at
  // which reset is pulsed. -1 disables either.
  task automatic run_eval(input int st, input int en, input int bi, input int th, input int md,
                          input int poke_c, input int rst_c,
                          output int lat1, output int lat2, output int encnt,
                          output int busycnt, output int donecnt1, output int donecnt2,
                          output int addr_err);
    lat1 = -1; lat2 = -1; encnt = 0; busycnt = 0; donecnt1 = 0; donecnt2 = 0; addr_err = 0;
    @(negedge clk);
    start_addr = 9'(st); end_addr = 9'(en); bias = 16'(bi); threshold = 16'(th);
    mode = 2'(md); enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1 enable = 1'b0;
      end
      if (rst_c >= 0 && c == rst_c + 2) rst_n = 1'b1;
      if (en1) begin
        encnt++;
        if (addr1 != 9'(st + c)) addr_err++;
      end
      if (busy1) busycnt++;
      if (done1) begin
        donecnt1++;
        if (lat1 < 0) lat1 = c;
      end
      if (done2) begin
        donecnt2++;
        if (lat2 < 0) lat2 = c;
      end
      if (c == poke_c) begin
        enable = 1'b1; mode = 2'd0; threshold = 16'sd32; bias = 16'sd0;
      end
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out",  out1, 0);
        chk("rst_mid_fire", fire1, 0);
        chk("rst_mid_busy", busy1, 0);
        chk("rst_mid_en",   en1, 0);
        chk("rst_mid_addr", addr1, 0);
        chk("rst_mid_busy2", busy2, 0);
      end
    end
  endtask

  typedef struct {
    int kind; int st; int en; int bi; int th; int md;
    int out; int fire; int lat; int n;
  } vec_t;

  vec_t vt [9];

  initial begin
    int l1, l2, ec, bc, dc1, dc2, ae;
    string nm;

    //           kind st en  bias  thr  md  out  fire lat n
    vt[0] = '{0, 0, 8,   0,   16, 2,  32,  1, 11, 8};
    vt[1] = '{0, 0, 8,   0,   40, 0,   0,  0, 11, 8};
    vt[2] = '{0, 0, 8,   0,   32, 0,   1,  1, 11, 8};
    vt[3] = '{1, 0, 4,  10,    0, 2, -50,  0,  7, 4};
    vt[4] = '{1, 0, 4,  10,    0, 1,   0,  0,  7, 4};
    vt[5] = '{2, 0, 8,   0,    0, 2, 32767, 1, 11, 8};
    vt[6] = '{0, 5, 5,   7,    0, 2,   7,  1,  2, 0};
    vt[7] = '{0, 0, 8,   0,  100, 3,  32,  0, 11, 8};
    vt[8] = '{0, 6, 3,  -4,   -5, 1,   0,  1,  2, 0};

    rst_n = 1'b0; enable = 1'b0; start_addr = '0; end_addr = '0;
    bias = '0; threshold = '0; mode = '0;
    load_mem(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out",  out1, 0);
    chk("reset_fire", fire1, 0);
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_en",   en1, 0);
    chk("reset_addr", addr1, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      load_mem(vt[i].kind);
      run_eval(vt[i].st, vt[i].en, vt[i].bi, vt[i].th, vt[i].md, -1, -1,
               l1, l2, ec, bc, dc1, dc2, ae);
      nm = $sformatf("v%0d", i);
      chk({nm, "_out"},   out1, vt[i].out);
      chk({nm, "_fire"},  fire1, vt[i].fire);
      chk({nm, "_lat"},   l1, vt[i].lat);
      chk({nm, "_encnt"}, ec, vt[i].n);
      chk({nm, "_busy"},  bc, vt[i].lat);
      chk({nm, "_done1"}, dc1, 1);
      chk({nm, "_addr"},  ae, 0);
      chk({nm, "_out_rl2"},  out2, vt[i].out);
      chk({nm, "_fire_rl2"}, fire2, vt[i].fire);
      chk({nm, "_lat_rl2"},  l2, (vt[i].n > 0) ? vt[i].lat + 1 : 2);
    end

    // Enable pulsed while busy: ignored, first result stands, single done.
    load_mem(0);
    run_eval(0, 8, 0, 16, 2, 3, -1, l1, l2, ec, bc, dc1, dc2, ae);
    chk("busy_en_out",   out1, 32);
    chk("busy_en_fire",  fire1, 1);
    chk("busy_en_done",  dc1, 1);
    chk("busy_en_lat",   l1, 11);
    chk("busy_en_busy",  bc, 11);

    // Enable in the done cycle: RL1 restarts (step, out 1); RL2 still busy, ignores it.
    run_eval(0, 8, 0, 16, 2, 11, -1, l1, l2, ec, bc, dc1, dc2, ae);
    chk("redo_done1",  dc1, 2);
    chk("redo_out1",   out1, 1);
    chk("redo_fire1",  fire1, 1);
    chk("redo_encnt",  ec, 16);
    chk("redo_done2",  dc2, 1);
    chk("redo_out2",   out2, 32);

    // Reset mid-RUN aborts without done, then a fresh evaluation works.
    run_eval(0, 8, 0, 16, 2, -1, 4, l1, l2, ec, bc, dc1, dc2, ae);
    chk("rst_no_done",  dc1, 0);
    chk("rst_no_done2", dc2, 0);
    run_eval(0, 8, 0, 16, 2, -1, -1, l1, l2, ec, bc, dc1, dc2, ae);
    chk("after_rst_out",  out1, 32);
    chk("after_rst_lat",  l1, 11);
    chk("after_rst_out2", out2, 32);
    chk("after_rst_lat2", l2, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
